cla_chunk_sequencer: RTL and testbench

Multi-cycle wide adder/subtractor controller. It time-shares one NUMBITS-wide carry-lookahead slice, built from p/g generation plus one `carry_look_ahead_logic` instance, across NUMCHUNKS chunks of a wide operand. It registers the inter-chunk carry so that a NUMBITS*NUMCHUNKS-bit add completes in NUMCHUNKS cycles. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/cla_chunk_sequencer.sv | 103 ++++++++++
 tb/tb_cla_chunk_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer: multi-cycle wide add/sub reusing one carry-lookahead slice per chunk
module carry_look_ahead_logic #(
  parameter int NUMBITS = 4
) (
  input  logic [NUMBITS-1:0] p,
  input  logic [NUMBITS-1:0] g,
  input  logic               c_in,
  output logic [NUMBITS:0]   c
);
  logic pp;
  // each carry as a flat sum of generate terms gated by the propagate chain above them
  always_comb begin
    c = '0;
    pp = 1'b1;
    c[0] = c_in;
    for (int i = 0; i < NUMBITS; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & c_in);
    end
  end
endmodule

module cla_chunk_sequencer #(
  parameter int NUMBITS   = 4,
  parameter int NUMCHUNKS = 4,
  parameter int W         = NUMBITS * NUMCHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         busy
);
  localparam int IW = NUMCHUNKS > 1 ? $clog2(NUMCHUNKS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, last, accept;
  logic [NUMBITS-1:0] a_c, b_c, p, g;
  logic [NUMBITS:0] c;
  assign accept = in_valid && state == IDLE;
  assign last = idx == IW'(NUMCHUNKS - 1);
  assign a_c = a_r[idx*NUMBITS +: NUMBITS];
  assign b_c = b_r[idx*NUMBITS +: NUMBITS];
  assign p = a_c ^ b_c;
  assign g = a_c & b_c;
  carry_look_ahead_logic #(.NUMBITS(NUMBITS)) u_cla (.p(p), .g(g), .c_in(carry), .c(c));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: accept from IDLE, leave RUN after the last chunk, release DONE on consumer ready
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = in_valid ? RUN : IDLE;
    else if (state == RUN) state_nx = last ? DONE : RUN;
    else state_nx = out_ready ? IDLE : DONE;
  end
  // handshake outputs decoded from registered state only
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  // operand capture on accept, then one chunk per RUN cycle written in place
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      sum <= '0;
      carry <= 1'b0;
      idx <= '0;
      c_out <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
      carry <= sub | c_in;
      idx <= '0;
    end else if (state == RUN) begin
      sum[idx*NUMBITS +: NUMBITS] <= p ^ c[NUMBITS-1:0];
      carry <= c[NUMBITS];
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        c_out <= c[NUMBITS];
        overflow <= c[NUMBITS] ^ c[NUMBITS-1];
      end
    end
endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// tb_cla_chunk_sequencer: random and directed checks against a transaction-level model
module tb_cla_chunk_sequencer;
  localparam int NB = 4, NC = 4, W = 16;
  logic clk = 0, rst_n = 1;
  logic in_valid = 0, in_ready, c_in = 0, sub = 0, out_valid, out_ready = 0;
  logic [W-1:0] a = 0, b = 0, sum;
  logic c_out, overflow, busy;
  int errs = 0, checks = 0;

  cla_chunk_sequencer #(.NUMBITS(NB), .NUMCHUNKS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // model: an operation occupies NC cycles, then the arithmetic result is published until taken
  logic m_busy = 0, m_valid = 0, m_co = 0, m_ov = 0, p_co = 0, p_ov = 0;
  logic [W-1:0] m_sum = 0, p_sum = 0;
  int m_left = 0;
  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] bb;
    logic [W:0] r;
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_left = 0; m_sum = 0; m_co = 0; m_ov = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        bb = sub ? ~b : b;
        r = {1'b0, a} + {1'b0, bb} + {16'd0, sub | c_in};
        p_sum = r[W-1:0];
        p_co = r[W];
        p_ov = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        m_busy = 1; m_left = NC;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1; m_sum = p_sum; m_co = p_co; m_ov = p_ov;
      end
    end else if (out_ready) begin
      m_valid = 0; m_busy = 0;
    end
  end

  // compare every cycle; the result fields are meaningful whenever no operation is in flight
  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    if (m_left == 0) begin
      check("sum", {16'd0, sum}, {16'd0, m_sum});
      check("c_out", {31'd0, c_out}, {31'd0, m_co});
      check("overflow", {31'd0, overflow}, {31'd0, m_ov});
    end
  end

  // caller is 2 time units after a rising edge with the block idle
  task automatic op(input string nm, input logic [W-1:0] ta, tb, input logic tc, ts,
                    input logic [W-1:0] es, input logic eco, eov);
    int n;
    check({nm, "_rdy"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1; out_ready = 1;
    @(posedge clk); #2;
    in_valid = 0; a = W'($urandom); b = W'($urandom); c_in = ~tc; sub = ~ts;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({nm, "_lat"}, n, NC);
    check({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
    check({nm, "_co"}, {31'd0, c_out}, {31'd0, eco});
    check({nm, "_ov"}, {31'd0, overflow}, {31'd0, eov});
    @(posedge clk); #2;
    check({nm, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic go_idle();
    int n = 0;
    in_valid = 0; out_ready = 1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("go_idle", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] edge_v [4];
    int n;
    edge_v[0] = 16'h0000; edge_v[1] = 16'hFFFF; edge_v[2] = 16'h7FFF; edge_v[3] = 16'h8000;
    #3 rst_n = 0;
    #1;
    check("rst_sum", {16'd0, sum}, 0);
    check("rst_co", {31'd0, c_out}, 0);
    check("rst_ov", {31'd0, overflow}, 0);
    check("rst_ovalid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_irdy", {31'd0, in_ready}, 1);
    #4 rst_n = 1;
    @(posedge clk); #2;
    op("ripple", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
    op("wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    op("ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    op("cin", 16'h1234, 16'h0000, 1, 0, 16'h1235, 0, 0);
    op("sub_neg", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
    op("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      in_valid = 1'($urandom);
      out_ready = ($urandom % 3) != 0;
      a = ($urandom % 4 == 0) ? edge_v[$urandom % 4] : W'($urandom);
      b = ($urandom % 4 == 0) ? edge_v[$urandom % 4] : W'($urandom);
      c_in = 1'($urandom);
      sub = 1'($urandom);
    end
    @(posedge clk); #2;
    go_idle();
    a = 16'h1111; b = 16'h2222; c_in = 0; sub = 0; in_valid = 1; out_ready = 0;
    @(posedge clk); #2;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #2;
      a = W'($urandom); b = W'($urandom);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      check("bp_valid", {31'd0, out_valid}, 1);
      check("bp_sum", {16'd0, sum}, 32'h3333);
      check("bp_irdy", {31'd0, in_ready}, 0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #2;
    check("bp_release", {31'd0, in_ready}, 1);
    op("after_bp", 16'h0100, 16'h0023, 0, 0, 16'h0123, 0, 0);
    a = 16'hFFFF; b = 16'h0001; c_in = 0; sub = 0; in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("mid_rst_sum", {16'd0, sum}, 0);
    check("mid_rst_co", {31'd0, c_out}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_irdy", {31'd0, in_ready}, 1);
    check("mid_rst_ovalid", {31'd0, out_valid}, 0);
    #2 rst_n = 1;
    @(posedge clk); #2;
    op("post_rst", 16'h0003, 16'h0004, 0, 0, 16'h0007, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
